riscv_l1_icache: RTL and testbench

//  Direct-mapped L1 instruction cache: the responder side of the fetch interface.

---
 rtl/riscv_l1_icache.sv | 126 ++++++++++++
 tb/tb_riscv_l1_icache.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_l1_icache.sv
// Direct-mapped L1 instruction cache. Hits return one cycle after accept at one per cycle.
// Misses stall the IF side (ready low) and refill one full line; the word arrives 1 cycle after the last beat.
module riscv_l1_icache #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic [31:0] imem_rdata,
    output logic        imem_valid,
    input  logic        flush,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESP} state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];

    logic [29:0]      miss_word_q;
    logic [OFF_W-1:0] beat_q;
    logic             flush_seen_q;

    logic [OFF_W-1:0] req_off, miss_off;
    logic [IDX_W-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0] req_tag, miss_tag;
    logic             hit, accept, refill_we, last_beat;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^if_req_addr[1:0];

    assign req_off  = if_req_addr[2 +: OFF_W];
    assign req_idx  = if_req_addr[2+OFF_W +: IDX_W];
    assign req_tag  = if_req_addr[31 -: TAG_W];
    assign miss_off = miss_word_q[0 +: OFF_W];
    assign miss_idx = miss_word_q[OFF_W +: IDX_W];
    assign miss_tag = miss_word_q[29 -: TAG_W];

    assign hit          = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign mem_req_addr = {miss_word_q[29:OFF_W], {(OFF_W+2){1'b0}}};

    always_comb begin
        state_d       = state_q;
        if_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        accept        = 1'b0;
        refill_we     = 1'b0;
        last_beat     = 1'b0;
        case (state_q)
            IDLE: begin
                // flush takes priority: a same-cycle request is simply not accepted
                if_req_ready = !flush;
                accept       = if_req_valid && !flush;
                if (accept && !hit) state_d = MISS_REQ;
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = REFILL;
            end
            REFILL: begin
                if (mem_rsp_valid) begin
                    refill_we = 1'b1;
                    if (beat_q == OFF_W'(LINE_WORDS-1)) begin
                        last_beat = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            valid_q      <= '0;
            imem_valid   <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_valid <= (accept && hit) || last_beat;
            if (state_q == MISS_REQ)
                beat_q <= '0;
            else if (refill_we)
                beat_q <= beat_q + OFF_W'(1);
            if (accept && !hit)
                flush_seen_q <= 1'b0;
            else if (flush)
                flush_seen_q <= 1'b1;
            // a flush anywhere during the miss leaves the refilled line invalid
            if (flush)
                valid_q <= '0;
            else if (last_beat && !flush_seen_q)
                valid_q[miss_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !hit)
            miss_word_q <= if_req_addr[31:2];
        if (refill_we)
            data_mem[{miss_idx, beat_q}] <= mem_rsp_data;
        if (last_beat)
            tag_mem[miss_idx] <= miss_tag;
        if (accept && hit)
            imem_rdata <= data_mem[{req_idx, req_off}];
        else if (refill_we && (beat_q == miss_off))
            imem_rdata <= mem_rsp_data;
    end

endmodule

// File: tb/tb_riscv_l1_icache.sv
// Directed bench for riscv_l1_icache: cold miss, hits, conflicts, stalls, flush and reset mid-miss.
module tb_riscv_l1_icache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    riscv_l1_icache #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_valid === 1'b1) pulse_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] addr);
        if_req_valid = 1'b1;
        if_req_addr  = addr;
        tick();
        if_req_valid = 1'b0;
    endtask

    task automatic grant();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic beats(input logic [31:0] base, input int gap);
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = base + 32'(i);
            tick();
            mem_rsp_valid = 1'b0;
            if (i < 3) repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (imem_valid !== 1'b0) begin n_bad++; $display("FAIL reset_imem_valid: got %b want 0", imem_valid); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (if_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", if_req_ready); end
    endtask

    task automatic test_cold_miss();
        int p0;
        req(32'h0000_1008);
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL cold_mem_req_valid: got %b want 1", mem_req_valid); end
        n_cmp++; if (mem_req_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL cold_mem_req_addr: got %h want 00001000", mem_req_addr); end
        n_cmp++; if (if_req_ready !== 1'b0) begin n_bad++; $display("FAIL cold_ready: got %b want 0", if_req_ready); end
        grant();
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL cold_req_drop: got %b want 0", mem_req_valid); end
        p0 = pulse_cnt;
        beats(32'hA0, 0);
        n_cmp++; if (pulse_cnt !== p0) begin n_bad++; $display("FAIL cold_early_pulse: got %0d want %0d", pulse_cnt, p0); end
        n_cmp++; if (imem_valid !== 1'b1) begin n_bad++; $display("FAIL cold_imem_valid: got %b want 1", imem_valid); end
        n_cmp++; if (imem_rdata !== 32'hA2) begin n_bad++; $display("FAIL cold_rdata: got %h want 000000a2", imem_rdata); end
        tick();
        n_cmp++; if (imem_valid !== 1'b0) begin n_bad++; $display("FAIL cold_pulse_width: got %b want 0", imem_valid); end
        n_cmp++; if (if_req_ready !== 1'b1) begin n_bad++; $display("FAIL cold_back_idle: got %b want 1", if_req_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h100C;
        exps[0]  = 32'hA0;   exps[1]  = 32'hA1;   exps[2]  = 32'hA3;
        if_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_req_addr = addrs[i];
            tick();
            n_cmp++; if (imem_valid !== 1'b1 || imem_rdata !== exps[i]) begin
                n_bad++; $display("FAIL hit_%0d: got valid=%b data=%h want valid=1 data=%h", i, imem_valid, imem_rdata, exps[i]);
            end
            n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL hit_%0d_no_mem_req: got %b want 0", i, mem_req_valid); end
        end
        if_req_valid = 1'b0;
        tick();
        n_cmp++; if (imem_valid !== 1'b0) begin n_bad++; $display("FAIL hit_streak_end: got %b want 0", imem_valid); end
    endtask

    task automatic test_conflict();
        req(32'h0000_1400);
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1400) begin
            n_bad++; $display("FAIL conflict_req: got valid=%b addr=%h want valid=1 addr=00001400", mem_req_valid, mem_req_addr);
        end
        grant();
        beats(32'hB0, 0);
        n_cmp++; if (imem_valid !== 1'b1 || imem_rdata !== 32'hB0) begin
            n_bad++; $display("FAIL conflict_rdata: got valid=%b data=%h want valid=1 data=000000b0", imem_valid, imem_rdata);
        end
        tick();
        req(32'h0000_1000);
        n_cmp++; if (mem_req_valid !== 1'b1 || imem_valid !== 1'b0) begin
            n_bad++; $display("FAIL conflict_evicted: got mem_req=%b imem_valid=%b want mem_req=1 imem_valid=0", mem_req_valid, imem_valid);
        end
        grant();
        beats(32'hA0, 0);
        n_cmp++; if (imem_rdata !== 32'hA0) begin n_bad++; $display("FAIL conflict_refill: got %h want 000000a0", imem_rdata); end
        tick();
    endtask

    task automatic test_stall();
        int stall_bad;
        req(32'h0000_3014);
        stall_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3010 || if_req_ready !== 1'b0) stall_bad++;
            tick();
        end
        n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_req_hold: got %0d bad cycles want 0", stall_bad); end
        grant();
        stall_bad = 0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hC0 + 32'(i);
            tick();
            mem_rsp_valid = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    if (if_req_ready !== 1'b0 || imem_valid !== 1'b0) stall_bad++;
                    tick();
                end
            end
        end
        n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_gap_ready: got %0d bad cycles want 0", stall_bad); end
        n_cmp++; if (imem_valid !== 1'b1 || imem_rdata !== 32'hC1) begin
            n_bad++; $display("FAIL stall_rdata: got valid=%b data=%h want valid=1 data=000000c1", imem_valid, imem_rdata);
        end
        tick();
        req(32'h0000_3018);
        n_cmp++; if (imem_valid !== 1'b1 || imem_rdata !== 32'hC2 || mem_req_valid !== 1'b0) begin
            n_bad++; $display("FAIL stall_line_hit: got valid=%b data=%h memreq=%b want 1/000000c2/0", imem_valid, imem_rdata, mem_req_valid);
        end
        tick();
    endtask

    task automatic test_flush();
        req(32'h0000_2000);
        grant();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hD0;
        tick();
        mem_rsp_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (if_req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_refill_ready: got %b want 0", if_req_ready); end
        for (int i = 1; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hD0 + 32'(i);
            tick();
        end
        mem_rsp_valid = 1'b0;
        n_cmp++; if (imem_valid !== 1'b1 || imem_rdata !== 32'hD0) begin
            n_bad++; $display("FAIL flush_resp: got valid=%b data=%h want valid=1 data=000000d0", imem_valid, imem_rdata);
        end
        tick();
        req(32'h0000_2000);
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL flush_line_invalid: got %b want 1", mem_req_valid); end
        grant();
        beats(32'hE0, 0);
        n_cmp++; if (imem_rdata !== 32'hE0) begin n_bad++; $display("FAIL flush_refill2: got %h want 000000e0", imem_rdata); end
        tick();
        flush = 1'b1; if_req_valid = 1'b1; if_req_addr = 32'h2000;
        #1;
        n_cmp++; if (if_req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_req_ready: got %b want 0", if_req_ready); end
        tick();
        flush = 1'b0; if_req_valid = 1'b0;
        n_cmp++; if (imem_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_req_taken: got imem_valid=%b mem_req=%b want 0/0", imem_valid, mem_req_valid);
        end
        req(32'h0000_2000);
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL flush_clears_all: got %b want 1", mem_req_valid); end
        grant();
        beats(32'hE0, 0);
        tick();
    endtask

    task automatic test_reset_mid_miss();
        int p0;
        req(32'h0000_1000);
        grant();
        beats(32'hA0, 0);
        tick();
        req(32'h0000_1000);
        n_cmp++; if (imem_valid !== 1'b1 || imem_rdata !== 32'hA0) begin
            n_bad++; $display("FAIL rst_prehit: got valid=%b data=%h want valid=1 data=000000a0", imem_valid, imem_rdata);
        end
        tick();
        req(32'h0000_1010);
        grant();
        p0 = pulse_cnt;
        mem_rsp_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin mem_rsp_data = 32'hF0 + 32'(i); tick(); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (imem_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_async: got imem_valid=%b mem_req=%b want 0/0", imem_valid, mem_req_valid);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 2; i < 4; i++) begin mem_rsp_data = 32'hF0 + 32'(i); tick(); end
        mem_rsp_valid = 1'b0;
        tick();
        n_cmp++; if (pulse_cnt !== p0) begin n_bad++; $display("FAIL rst_no_pulse: got %0d pulses want %0d", pulse_cnt, p0); end
        n_cmp++; if (if_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b want 1", if_req_ready); end
        req(32'h0000_1000);
        n_cmp++; if (mem_req_valid !== 1'b1 || imem_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid_cleared: got mem_req=%b imem_valid=%b want 1/0", mem_req_valid, imem_valid);
        end
        grant();
        beats(32'hA0, 0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; if_req_valid = 1'b0; if_req_addr = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_stall();
        test_flush();
        test_reset_mid_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
